// File: rtl/pc_unit_pkg.sv
// Shared fetch-stage definitions: PC width default, write_src encoding,
// and the loop-stack operation decode used by pc_unit's LIFO.
package definitions;

  localparam int unsigned DEF_PC_WIDTH = 16;

  typedef enum logic {
    PC_INC   = 1'b0,
    PC_STACK = 1'b1
  } pc_src_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_SWAP,
    OP_OVF,
    OP_UDF
  } stack_op_t;

  // push+pop on an empty stack degrades to a plain push
  function automatic stack_op_t stack_decode(
    input logic push,
    input logic pop,
    input logic empty,
    input logic full
  );
    stack_op_t op;
    op = OP_NONE;
    unique case (1'b1)
      push && pop && !empty:
        op = OP_SWAP;
      push && !full && (!pop || empty):
        op = OP_PUSH;
      push && full && !pop:
        op = OP_OVF;
      pop && !push && !empty:
        op = OP_POP;
      pop && !push && empty:
        op = OP_UDF;
      default:
        op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// PC control <-> pc_unit bundle: per-cycle controls in,
// registered fetch address and loop-stack status out.
interface pc_unit_if #(
  parameter int PC_WIDTH    = 16,
  parameter int STACK_DEPTH = 16
);
  localparam int DW = $clog2(STACK_DEPTH) + 1;

  logic                write_enable;
  logic                write_src;
  logic                push;
  logic                pop;
  logic [PC_WIDTH-1:0] pc;
  logic [DW-1:0]       depth;
  logic                stack_empty;
  logic                stack_full;
  logic                overflow_err;
  logic                underflow_err;

  modport master (
    output write_enable,
    output write_src,
    output push,
    output pop,
    input  pc,
    input  depth,
    input  stack_empty,
    input  stack_full,
    input  overflow_err,
    input  underflow_err
  );

  modport slave (
    input  write_enable,
    input  write_src,
    input  push,
    input  pop,
    output pc,
    output depth,
    output stack_empty,
    output stack_full,
    output overflow_err,
    output underflow_err
  );

endinterface

// File: rtl/pc_unit_loop_stack.sv
// Parameterised LIFO of loop-return addresses; top is read
// combinationally from the registered array, errors are strobes.
module loop_stack
  import definitions::*;
#(
  parameter int W  = 16,
  parameter int D  = 16,
  localparam int AW = $clog2(D),
  localparam int DW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  top,
  output logic [DW-1:0] depth,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_en;
  logic [DW-1:0] depth_nxt;
  stack_op_t     op;

  assign empty   = (depth == '0);
  assign full    = (depth == DW'(D));
  assign top_idx = depth[AW-1:0] - AW'(1);
  assign top     = mem[top_idx];
  assign op      = stack_decode(push, pop, empty, full);

  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = depth[AW-1:0];
    depth_nxt = depth;
    overflow  = 1'b0;
    underflow = 1'b0;
    unique case (op)
      OP_PUSH: begin
        wr_en     = 1'b1;
        depth_nxt = depth + DW'(1);
      end
      OP_SWAP: begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end
      OP_POP:  depth_nxt = depth - DW'(1);
      OP_OVF:  overflow  = 1'b1;
      OP_UDF:  underflow = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
    end else begin
      depth <= depth_nxt;
    end
  end

  // contents are don't-care after reset, so no reset on the array
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wdata;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register: increments or reloads from the loop stack,
// gated by PC control's write_enable; owns the sticky error flags.
module pc_unit
  import definitions::*;
#(
  parameter int                  PC_WIDTH    = DEF_PC_WIDTH,
  parameter int                  STACK_DEPTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_unit_if.slave  bus
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] top;
  logic                st_push;
  logic                st_pop;
  logic                empty;
  logic                full;
  logic                ovf_s;
  logic                udf_s;
  logic                branch;
  logic                ovf_q;
  logic                udf_q;

  assign pc_inc  = pc_q + PC_WIDTH'(1);
  assign st_push = bus.write_enable && bus.push;
  assign st_pop  = bus.write_enable && bus.pop;
  assign branch  = bus.write_enable
                && (pc_src_t'(bus.write_src) == PC_STACK);

  loop_stack #(
    .W (PC_WIDTH),
    .D (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (st_push),
    .pop       (st_pop),
    .wdata     (pc_inc),
    .top       (top),
    .depth     (bus.depth),
    .empty     (empty),
    .full      (full),
    .overflow  (ovf_s),
    .underflow (udf_s)
  );

  // a branch on an empty stack falls through to pc+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (bus.write_enable) begin
      pc_q  <= (branch && !empty) ? top : pc_inc;
      ovf_q <= ovf_q | ovf_s;
      udf_q <= udf_q | udf_s | (branch && empty);
    end
  end

  assign bus.pc            = pc_q;
  assign bus.stack_empty   = empty;
  assign bus.stack_full    = full;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = udf_q;

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter register and loop-target stack for the BeeF fetch stage. It sits directly downstream of the PC control stage and consumes that stage's `write_enable` (bubble gating) and `write_src` (branch select) each cycle. It produces the fetch address. It keeps a LIFO of loop-return addresses so that a taken backward branch reloads the PC from the stack top instead of incrementing.

## Interface
- `PC_WIDTH`, 16, width of the program counter and of stack entries.
- `STACK_DEPTH`, 16, number of loop-target entries; power of two, ≥2.
- `RESET_PC`, 0, PC value loaded on reset.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `write_enable`  in  1  from PC control; 1 = update state this cycle, 0 = bubble/hold.
- `write_src`  in  1  from PC control; 1 = load PC from stack top, 0 = PC+1.
- `push`  in  1  loop open; store PC+1 as loop target.
- `pop`  in  1  loop exit; discard stack top.
- `pc`  out  PC_WIDTH  current fetch address (registered).
- `depth`  out  $clog2(STACK_DEPTH)+1  current stack occupancy (registered).
- `stack_empty`  out  1  depth == 0.
- `stack_full`  out  1  depth == STACK_DEPTH.
- `overflow_err`  out  1  sticky; a push was attempted while full.
- `underflow_err`  out  1  sticky; a pop or branch was attempted while empty.

## Operation
- Reset (rst_n=0, async): pc=RESET_PC, depth=0, overflow_err=0, underflow_err=0, therefore stack_empty=1 and stack_full=0. Stack contents are don't-care.
- write_enable=0: pc, depth, stack contents and error flags hold; push, pop and write_src are ignored.
- write_enable=1, next PC:
  - write_src=1 and not empty: pc <= top.
  - write_src=1 and empty: pc <= pc+1, and underflow_err is set.
  - write_src=0: pc <= pc+1.
  - Increment wraps modulo 2^PC_WIDTH; all-ones wraps to 0.
- write_enable=1, stack update (independent of write_src):
  - push only, not full: entry[depth] <= pc+1 (pre-update pc, wrapped); depth+1.
  - push only, full: no write, depth unchanged, overflow_err set.
  - pop only, not empty: depth−1.
  - pop only, empty: no change, underflow_err set.
  - push and pop together, not empty: top entry overwritten with pc+1; depth unchanged.
  - push and pop together, empty: treated as push; underflow_err is not set.
- Branch and pop in the same cycle: pc loads the old top, then the entry is discarded.
- Branch and push in the same cycle: pc loads the old top, and the new entry becomes the top for later cycles.
- Error flags are cleared only by reset. The error flags never block PC advance.

## Timing
- All state updates on the rising clk edge. Outputs are registered, and empty/full are decoded from the registered depth.
- Latency: inputs sampled at edge N are reflected on pc/depth immediately after edge N; one cycle.
- The top entry is read combinationally from the registered stack.
  - A branch at edge N sees pushes committed at or before edge N−1.
- PC control alternates bubble cycles, so pc updates at most every other edge in normal operation. pc_unit imposes no such restriction.
- Reset deasserts synchronously with respect to clk upstream. Assertion mid-operation clears state immediately, regardless of clk.

## Structure
- Shared package `definitions`: add the `PC_WIDTH` default constant and the `pc_src_t` enum (PC_INC=0, PC_STACK=1). The `write_src` encoding is defined there and shared with PC control.
- Sub-module `loop_stack`, a parameterised LIFO:
  - inputs: push, pop, wdata.
  - outputs: top, depth, empty, full, and per-cycle overflow/underflow strobes.
  - pc_unit owns the pc register and the sticky flags.

## Test plan
- Reset mid-run: drive pc to 0x0005, assert rst_n=0 between edges. pc=0x0000, depth=0, stack_empty=1, both errors 0 immediately, before the next edge.
- Bubble hold: pc=0x0010, write_enable=0 with push=1 and write_src=1 for 3 cycles. pc stays 0x0010, depth stays 0.
- Loop:
  - At pc=0x0003, push with write_enable=1: pc=0x0004, top=0x0004, depth=1.
  - Advance to 0x0009, then write_src=1: pc=0x0004, depth=1.
  - Later, branch+pop at pc=0x0009: pc=0x0004, depth=0.
- Full/overflow (STACK_DEPTH=4): 5 enabled pushes. depth=4, stack_full=1, overflow_err=1 after the fifth, and the top still holds the fourth pushed value.
- Empty/underflow: from reset, write_src=1 then pop. pc goes 0x0000→0x0001→0x0002, underflow_err=1, depth=0.
- Wrap and simultaneous push+pop: pc=0xFFFF with depth=1, push+pop. pc=0x0000, top=0x0000, depth=1, no errors.
